pkt_fifo_ctrl: RTL

PKT_FIFO_CTRL -- requirements
Module: pkt_fifo_ctrl

---
 rtl/pkt_fifo_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pkt_fifo_ctrl.sv
// Store-and-forward packet buffer with CPU window and optional hold-for-edit before drain.
// Words leave on the first cycle after EOP (or after the 0x300 release); out_wr follows out_rdy, and in_rdy is low while a packet is held or draining.
module pkt_fifo_ctrl #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH/8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  in_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   input  logic [9:0]            cpu_in_addr,
   input  logic [63:0]           cpu_in_data,
   input  logic                  cpu_in_wen,
   output logic [63:0]           cpu_out_data
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      HOLD  = 3'd2,
      DRAIN = 3'd3,
      DROP  = 3'd4
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] head, tail;
   logic                  mode, seen_zero, packet_rdy;
   logic [31:0]           pkt_cnt, drop_cnt;

   logic [DATA_WIDTH-1:0] buf_data [DEPTH];
   logic [CTRL_WIDTH-1:0] buf_ctrl [DEPTH];

   logic                  in_acc, ctrl_zero, is_eop, buf_full, last_out;
   logic                  reg_sel, dat_sel, ctl_sel;
   logic [7:0]            reg_off;
   logic [ADDR_WIDTH-1:0] win_off;
   logic                  done_wr, mode_wr, clr_wr, win_wr;
   logic                  pkt_done, drop_done;

   assign in_rdy     = (state == IDLE) || (state == FILL) || (state == DROP);
   assign in_acc     = in_wr && in_rdy;
   assign ctrl_zero  = (in_ctrl == '0);
   assign is_eop     = in_acc && !ctrl_zero && seen_zero;
   assign buf_full   = (tail == '1);
   assign packet_rdy = (state == HOLD);

   assign out_wr   = (state == DRAIN) && out_rdy && (head != tail);
   assign out_data = buf_data[head];
   assign out_ctrl = buf_ctrl[head];
   assign last_out = out_wr && ((head + ADDR_ONE) == tail);

   assign reg_sel = (cpu_in_addr[9:8] == 2'b11);
   assign dat_sel = (cpu_in_addr[9:8] == 2'b10);
   assign ctl_sel = (cpu_in_addr[9:8] == 2'b01);
   assign reg_off = cpu_in_addr[7:0];
   assign win_off = cpu_in_addr[ADDR_WIDTH-1:0];

   assign done_wr = cpu_in_wen && reg_sel && (reg_off == 8'h00);
   assign mode_wr = cpu_in_wen && reg_sel && (reg_off == 8'h04);
   assign clr_wr  = cpu_in_wen && reg_sel && (reg_off == 8'h07);
   assign win_wr  = cpu_in_wen && (state == HOLD);

   assign pkt_done  = last_out;
   assign drop_done = is_eop && ((state == DROP) || ((state == FILL) && buf_full));

   always_comb begin
      cpu_out_data = '0;
      if (!cpu_in_wen) begin
         if (reg_sel) begin
            case (reg_off)
               8'h01:   cpu_out_data = {56'b0, state, 4'b0, packet_rdy};
               8'h02:   cpu_out_data = 64'(head);
               8'h03:   cpu_out_data = 64'(tail);
               8'h04:   cpu_out_data = {63'b0, mode};
               8'h05:   cpu_out_data = {32'b0, pkt_cnt};
               8'h06:   cpu_out_data = {32'b0, drop_cnt};
               default: cpu_out_data = '0;
            endcase
         end else if (dat_sel) begin
            cpu_out_data = 64'(buf_data[win_off]);
         end else if (ctl_sel) begin
            cpu_out_data = 64'(buf_ctrl[win_off]);
         end
      end
   end

   // Storage is not reset; tail is 0 in IDLE, so one write port covers IDLE and FILL.
   always_ff @(posedge clk) begin
      if (in_acc && (state != DROP) && !buf_full) begin
         buf_data[tail] <= in_data;
         buf_ctrl[tail] <= in_ctrl;
      end else if (win_wr && dat_sel) begin
         buf_data[win_off] <= DATA_WIDTH'(cpu_in_data);
      end else if (win_wr && ctl_sel) begin
         buf_ctrl[win_off] <= CTRL_WIDTH'(cpu_in_data);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         head      <= '0;
         tail      <= '0;
         mode      <= 1'b0;
         seen_zero <= 1'b0;
         pkt_cnt   <= '0;
         drop_cnt  <= '0;
      end else begin
         if (mode_wr) mode <= cpu_in_data[0];

         case (state)
            IDLE: begin
               if (in_acc) begin
                  tail      <= ADDR_ONE;
                  seen_zero <= ctrl_zero;
                  state     <= FILL;
               end
            end
            FILL: begin
               if (in_acc) begin
                  if (ctrl_zero) seen_zero <= 1'b1;
                  if (buf_full) begin
                     // Packet too long for the buffer: abandon it.
                     if (is_eop) begin
                        state <= IDLE;
                        head  <= '0;
                        tail  <= '0;
                     end else begin
                        state <= DROP;
                     end
                  end else begin
                     tail <= tail + ADDR_ONE;
                     if (is_eop) state <= mode ? HOLD : DRAIN;
                  end
               end
            end
            DROP: begin
               if (in_acc) begin
                  if (ctrl_zero) seen_zero <= 1'b1;
                  if (is_eop) begin
                     state <= IDLE;
                     head  <= '0;
                     tail  <= '0;
                  end
               end
            end
            HOLD: begin
               if (done_wr) state <= DRAIN;
            end
            DRAIN: begin
               if (last_out) begin
                  state <= IDLE;
                  head  <= '0;
                  tail  <= '0;
               end else if (out_wr) begin
                  head <= head + ADDR_ONE;
               end
            end
            default: state <= IDLE;
         endcase

         if (clr_wr) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
         end else begin
            if (pkt_done)  pkt_cnt  <= pkt_cnt + 32'd1;
            if (drop_done) drop_cnt <= drop_cnt + 32'd1;
         end
      end
   end
endmodule
